// File: rtl/cw305_pmul_seq.sv
// Pointwise modular multiply sequencer: walks pWORDS key/operand words and
// writes back k*gx mod Q and k*gy mod Q per 16-bit lane.
module cw305_pmul_seq #(
    parameter int unsigned pQ      = 3329,
    parameter int unsigned pWORDS  = 8,
    parameter int unsigned pCOEF_W = 16
) (
    input  logic        crypto_clk,
    input  logic        reset_n_i,
    input  logic        I_start,
    output logic        O_ready,
    output logic        O_busy,
    output logic        O_done,
    output logic [7:0]  O_k_addr,
    input  logic [31:0] I_k_word,
    output logic [2:0]  O_gx_addr,
    output logic [2:0]  O_gy_addr,
    input  logic [31:0] I_gx_word,
    input  logic [31:0] I_gy_word,
    output logic [2:0]  O_rx_addr,
    output logic [2:0]  O_ry_addr,
    output logic        O_rx_wren,
    output logic        O_ry_wren,
    output logic [31:0] O_rx_word,
    output logic [31:0] O_ry_word
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_CAPT = 3'd2,
        S_MUL  = 3'd3,
        S_RED  = 3'd4,
        S_WR   = 3'd5,
        S_DONE = 3'd6
    } state_e;

    localparam logic [2:0]  IDX_LAST = 3'(pWORDS - 1);
    localparam logic [31:0] MOD_Q    = 32'(pQ);

    state_e state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic [31:0]      k_q, k_d, gx_q, gx_d, gy_q, gy_d;
    logic [1:0][31:0] px_q, px_d, py_q, py_d;
    logic [31:0]      rx_word_q, rx_word_d, ry_word_q, ry_word_d;
    logic             ready_q, ready_d, busy_q, busy_d, done_q, done_d, wren_q, wren_d;

    // Full-width remainder keeps the result exact even for lane operands >= pQ.
    function automatic logic [pCOEF_W-1:0] mod_q(input logic [31:0] p);
        logic [31:0] r;
        r = p % MOD_Q;
        return r[pCOEF_W-1:0];
    endfunction

    // State, index and registered status outputs.
    always_ff @(posedge crypto_clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= S_IDLE;
            idx_q   <= 3'd0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wren_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            wren_q  <= wren_d;
        end
    end

    // Next-state and word index sequencing.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: begin
                if (I_start) begin
                    state_d = S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: state_d = S_CAPT;
            S_CAPT: state_d = S_MUL;
            S_MUL:  state_d = S_RED;
            S_RED:  state_d = S_WR;
            S_WR: begin
                if (idx_q == IDX_LAST) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_LOAD;
                    idx_d   = idx_q + 3'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                idx_d   = 3'd0;
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = 3'd0;
            end
        endcase
    end

    // Status decodes from the next state so the flops line up with the state.
    always_comb begin
        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_DONE);
        wren_d  = (state_d == S_WR);
    end

    // Datapath register updates for capture, multiply and reduce.
    always_comb begin
        k_d       = k_q;
        gx_d      = gx_q;
        gy_d      = gy_q;
        px_d      = px_q;
        py_d      = py_q;
        rx_word_d = rx_word_q;
        ry_word_d = ry_word_q;
        case (state_q)
            S_CAPT: begin
                k_d  = I_k_word;
                gx_d = I_gx_word;
                gy_d = I_gy_word;
            end
            S_MUL: begin
                for (int j = 0; j < 2; j++) begin
                    px_d[j] = {16'd0, k_q[pCOEF_W*j +: pCOEF_W]} * {16'd0, gx_q[pCOEF_W*j +: pCOEF_W]};
                    py_d[j] = {16'd0, k_q[pCOEF_W*j +: pCOEF_W]} * {16'd0, gy_q[pCOEF_W*j +: pCOEF_W]};
                end
            end
            S_RED: begin
                rx_word_d = {mod_q(px_q[1]), mod_q(px_q[0])};
                ry_word_d = {mod_q(py_q[1]), mod_q(py_q[0])};
            end
            default: begin
                rx_word_d = rx_word_q;
            end
        endcase
    end

    // Datapath flops; the result words hold between writes.
    always_ff @(posedge crypto_clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            k_q       <= 32'd0;
            gx_q      <= 32'd0;
            gy_q      <= 32'd0;
            px_q      <= '0;
            py_q      <= '0;
            rx_word_q <= 32'd0;
            ry_word_q <= 32'd0;
        end else begin
            k_q       <= k_d;
            gx_q      <= gx_d;
            gy_q      <= gy_d;
            px_q      <= px_d;
            py_q      <= py_d;
            rx_word_q <= rx_word_d;
            ry_word_q <= ry_word_d;
        end
    end

    assign O_ready   = ready_q;
    assign O_busy    = busy_q;
    assign O_done    = done_q;
    assign O_rx_wren = wren_q;
    assign O_ry_wren = wren_q;
    assign O_rx_word = rx_word_q;
    assign O_ry_word = ry_word_q;
    assign O_k_addr  = {5'd0, idx_q};
    assign O_gx_addr = idx_q;
    assign O_gy_addr = idx_q;
    assign O_rx_addr = idx_q;
    assign O_ry_addr = idx_q;

endmodule

// File: tb/tb_cw305_pmul_seq.sv
// Directed bench for cw305_pmul_seq with a register-block memory model and a
// scoreboard of expected write-backs.
module tb_cw305_pmul_seq;

    logic        crypto_clk = 1'b0;
    logic        reset_n_i;
    logic        I_start;
    logic        O_ready, O_busy, O_done;
    logic [7:0]  O_k_addr;
    logic [31:0] I_k_word, I_gx_word, I_gy_word;
    logic [2:0]  O_gx_addr, O_gy_addr, O_rx_addr, O_ry_addr;
    logic        O_rx_wren, O_ry_wren;
    logic [31:0] O_rx_word, O_ry_word;

    logic [31:0] k_mem [8];
    logic [31:0] gx_mem [8];
    logic [31:0] gy_mem [8];
    logic [31:0] rx_seen [8];
    logic [31:0] ry_seen [8];

    typedef struct {
        logic [2:0]  a;
        logic [31:0] rx;
        logic [31:0] ry;
    } exp_t;
    exp_t exp_q [$];

    int n_assert = 0;
    int n_fail   = 0;

    cw305_pmul_seq dut (
        .crypto_clk (crypto_clk),
        .reset_n_i  (reset_n_i),
        .I_start    (I_start),
        .O_ready    (O_ready),
        .O_busy     (O_busy),
        .O_done     (O_done),
        .O_k_addr   (O_k_addr),
        .I_k_word   (I_k_word),
        .O_gx_addr  (O_gx_addr),
        .O_gy_addr  (O_gy_addr),
        .I_gx_word  (I_gx_word),
        .I_gy_word  (I_gy_word),
        .O_rx_addr  (O_rx_addr),
        .O_ry_addr  (O_ry_addr),
        .O_rx_wren  (O_rx_wren),
        .O_ry_wren  (O_ry_wren),
        .O_rx_word  (O_rx_word),
        .O_ry_word  (O_ry_word)
    );

    always #5 crypto_clk = ~crypto_clk;

    // Register block model: key is combinational, operands have one cycle of latency.
    assign I_k_word = k_mem[O_k_addr[2:0]];
    always_ff @(posedge crypto_clk) begin
        I_gx_word <= gx_mem[O_gx_addr];
        I_gy_word <= gy_mem[O_gy_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [15:0] mm(input logic [15:0] a, input logic [15:0] b);
        int unsigned p;
        int unsigned r;
        p = int'(a) * int'(b);
        r = p % 3329;
        return r[15:0];
    endfunction

    task automatic push_expected();
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            e.a  = 3'(i);
            e.rx = {mm(k_mem[i][31:16], gx_mem[i][31:16]), mm(k_mem[i][15:0], gx_mem[i][15:0])};
            e.ry = {mm(k_mem[i][31:16], gy_mem[i][31:16]), mm(k_mem[i][15:0], gy_mem[i][15:0])};
            exp_q.push_back(e);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_ready"}, {31'd0, O_ready}, 32'd1);
        chk({tag, "_busy"},  {31'd0, O_busy},  32'd0);
        chk({tag, "_done"},  {31'd0, O_done},  32'd0);
        chk({tag, "_wren"},  {30'd0, O_rx_wren, O_ry_wren}, 32'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge crypto_clk);
            check_idle("idle");
        end
    endtask

    task automatic check_cycle(input int c, inout int wr_cnt, inout int dn_cnt);
        exp_t e;
        logic exp_wr;
        exp_wr = (c % 5 == 0) && (c <= 40);
        chk("rx_wren", {31'd0, O_rx_wren}, {31'd0, exp_wr});
        chk("ry_wren", {31'd0, O_ry_wren}, {31'd0, exp_wr});
        chk("done",    {31'd0, O_done},    {31'd0, c == 41});
        chk("busy",    {31'd0, O_busy},    {31'd0, c <= 41});
        chk("ready",   {31'd0, O_ready},   {31'd0, c > 41});
        if (c <= 40) begin
            chk("k_addr",  {24'd0, O_k_addr},  32'((c - 1) / 5));
            chk("gy_addr", {29'd0, O_gy_addr}, 32'((c - 1) / 5));
        end
        if (O_done) dn_cnt++;
        if (O_rx_wren) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
                chk("sb_empty", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("rx_addr", {29'd0, O_rx_addr}, {29'd0, e.a});
                chk("ry_addr", {29'd0, O_ry_addr}, {29'd0, e.a});
                chk("rx_word", O_rx_word, e.rx);
                chk("ry_word", O_ry_word, e.ry);
                rx_seen[O_rx_addr] = O_rx_word;
                ry_seen[O_ry_addr] = O_ry_word;
            end
        end
    endtask

    // One operation from a start pulse; e1/e2 place extra start pulses, abort_at resets mid-run.
    task automatic run(input int e1, input int e2, input int abort_at);
        int wr_cnt;
        int dn_cnt;
        wr_cnt = 0;
        dn_cnt = 0;
        push_expected();
        I_start = 1'b1;
        for (int c = 1; c <= 42; c++) begin
            if (c == abort_at) begin
                @(posedge crypto_clk);
                #2 reset_n_i = 1'b0;
                #1;
                check_idle("abort");
                chk("abort_rx_word", O_rx_word, 32'd0);
                exp_q.delete();
                @(negedge crypto_clk);
                @(negedge crypto_clk);
                reset_n_i = 1'b1;
                @(negedge crypto_clk);
                check_idle("post_abort");
                return;
            end
            @(negedge crypto_clk);
            check_cycle(c, wr_cnt, dn_cnt);
            I_start = (c + 1 == e1) || (c + 1 == e2);
        end
        chk("write_count", 32'(wr_cnt), 32'd8);
        chk("done_count",  32'(dn_cnt), 32'd1);
        chk("sb_drained",  32'(exp_q.size()), 32'd0);
    endtask

    task automatic fill_random();
        for (int i = 0; i < 8; i++) begin
            k_mem[i]  = $urandom;
            gx_mem[i] = $urandom;
            gy_mem[i] = $urandom;
        end
    endtask

    initial begin
        reset_n_i = 1'b0;
        I_start   = 1'b0;
        for (int i = 0; i < 8; i++) begin
            k_mem[i] = 32'd0; gx_mem[i] = 32'd0; gy_mem[i] = 32'd0;
            rx_seen[i] = 32'd0; ry_seen[i] = 32'd0;
        end
        repeat (3) @(negedge crypto_clk);
        check_idle("reset");
        chk("reset_k_addr",  {24'd0, O_k_addr}, 32'd0);
        chk("reset_rx_word", O_rx_word, 32'd0);
        chk("reset_ry_word", O_ry_word, 32'd0);
        reset_n_i = 1'b1;
        idle(2);

        // Lane pass-through with unit key.
        fill_random();
        for (int i = 0; i < 8; i++) k_mem[i] = 32'h0001_0001;
        gx_mem[0] = 32'h0BCD_0123;
        gy_mem[0] = 32'hFFFF_0D01;
        run(0, 0, 0);
        chk("t1_rx0", rx_seen[0], 32'h0BCD_0123);
        chk("t1_ry0", ry_seen[0], 32'h08EC_0000);
        idle(2);
        chk("t1_hold_rx", O_rx_word, rx_seen[7]);

        // Maximum operands.
        for (int i = 0; i < 8; i++) begin
            k_mem[i] = 32'hFFFF_FFFF; gx_mem[i] = 32'hFFFF_FFFF; gy_mem[i] = 32'hFFFF_FFFF;
        end
        run(0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            chk("t2_rx", rx_seen[i], 32'h0071_0071);
            chk("t2_ry", ry_seen[i], 32'h0071_0071);
        end
        idle(1);

        // Start pulses during busy and done are ignored.
        fill_random();
        run(12, 41, 0);
        idle(10);

        // Reset mid-operation, then a clean run.
        fill_random();
        run(0, 0, 17);
        fill_random();
        run(0, 0, 0);

        // Back-to-back runs with new data for the second.
        fill_random();
        run(0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            k_mem[i] = 32'h0002_0002; gx_mem[i] = 32'h0681_0681;
        end
        run(0, 0, 0);
        for (int i = 0; i < 8; i++) chk("t6_rx", rx_seen[i], 32'h0001_0001);
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
